// File: rtl/serial_word_receiver.sv
// Serial-in, parallel-out receiver: frames MSB-first bits into WIDTH-bit words
// and hands each word to a one-entry valid/ready buffer with a sticky overrun flag.
module serial_word_receiver #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sh,
  input  logic             si,
  input  logic             sof,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  input  logic             q_ready,
  output logic             busy,
  output logic             overrun,
  input  logic             clr_ovr
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sreg_r, sreg_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic [WIDTH-1:0] q_r, q_s;
  logic             q_valid_r, q_valid_s;
  logic             overrun_r, overrun_s;
  logic             busy_r;
  logic [WIDTH-1:0] word_s;
  logic             complete_s;
  logic             accept_s;

  // Bit framing: sof re-aligns to bit 0, otherwise the count alone closes a word.
  always_comb begin
    word_s     = {sreg_r[WIDTH-2:0], si};
    sreg_s     = sreg_r;
    cnt_s      = cnt_r;
    complete_s = 1'b0;
    if (sh) begin
      sreg_s = word_s;
      if (sof) begin
        cnt_s = CNT_ONE;
      end else if (cnt_r == CNT_LAST) begin
        cnt_s      = CNT_ZERO;
        complete_s = 1'b1;
      end else begin
        cnt_s = cnt_r + CNT_ONE;
      end
    end else begin
      sreg_s = sreg_r;
    end
  end

  // One-entry output buffer; a completion that cannot be stored sets overrun,
  // and that set outranks a same-edge clr_ovr.
  always_comb begin
    accept_s  = q_valid_r & q_ready;
    q_s       = q_r;
    q_valid_s = q_valid_r;
    if (clr_ovr) begin
      overrun_s = 1'b0;
    end else begin
      overrun_s = overrun_r;
    end
    if (complete_s && (!q_valid_r || accept_s)) begin
      q_s       = word_s;
      q_valid_s = 1'b1;
    end else if (complete_s) begin
      overrun_s = 1'b1;
    end else if (accept_s) begin
      q_valid_s = 1'b0;
    end else begin
      q_valid_s = q_valid_r;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_r    <= {WIDTH{1'b0}};
      cnt_r     <= CNT_ZERO;
      q_r       <= {WIDTH{1'b0}};
      q_valid_r <= 1'b0;
      overrun_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      sreg_r    <= sreg_s;
      cnt_r     <= cnt_s;
      q_r       <= q_s;
      q_valid_r <= q_valid_s;
      overrun_r <= overrun_s;
      busy_r    <= (cnt_s != CNT_ZERO);
    end
  end

  assign q       = q_r;
  assign q_valid = q_valid_r;
  assign overrun = overrun_r;
  assign busy    = busy_r;

endmodule
